// File: rtl/eth_rx_buf_pkg.sv
// Shared types and constants for the Ethernet receive buffer writer.
package eth_rx_buf_pkg;

   localparam int unsigned SLOT_BYTES  = 2048;
   localparam int unsigned FCS_BYTES   = 4;
   // Descriptor slot field is sized for the largest supported BUF_COUNT (256).
   localparam int unsigned DESC_SLOT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DROP,
      COMMIT
   } rx_state_e;

   typedef struct packed {
      logic [11:0]            len;
      logic [DESC_SLOT_W-1:0] slot;
      logic                   err;
   } rx_desc_t;

endpackage

// File: rtl/eth_rx_desc_fifo.sv
// Synchronous descriptor FIFO; DEPTH must be a power of two.
module eth_rx_desc_fifo
   import eth_rx_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  rx_desc_t push_desc,
   output logic     pop_valid,
   input  logic     pop_ready,
   output rx_desc_t pop_desc
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   rx_desc_t         mem_q [DEPTH];
   rx_desc_t         mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      pop_valid = (cnt_q != '0);
      do_push   = push && (cnt_q != CNT_W'(DEPTH));
      do_pop    = pop_valid && pop_ready;
      pop_desc  = pop_valid ? mem_q[rd_ptr_q] : '0;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_desc;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/eth_rx_buf_writer.sv
// Steers MAC receive bytes into fixed 2 KiB buffer slots and emits per-frame descriptors.
// Optional: define ETH_RX_FCS_STRIP_EN to report lengths without FCS and drop frames <= 4 bytes.
module eth_rx_buf_writer
   import eth_rx_buf_pkg::*;
#(
   parameter int unsigned BUF_COUNT = 8,
   parameter int unsigned SLOT_HW_W = 10,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   input  logic                         s_axis_tuser,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [15:0]                  mem_din,
   output logic [1:0]                   mem_we,
   output logic                         mem_en,
   output logic                         desc_valid,
   input  logic                         desc_ready,
   output logic [11:0]                  desc_len,
   output logic [$clog2(BUF_COUNT)-1:0] desc_slot,
   output logic                         desc_err,
   input  logic                         buf_release,
   output logic [CNT_W-1:0]             drop_count
);

   localparam int unsigned SLOT_W = $clog2(BUF_COUNT);
   localparam int unsigned OCC_W  = $clog2(BUF_COUNT + 1);

   rx_state_e          state_q, state_d;
   logic               ready_q, ready_d;
   logic               sof_ok_q, sof_ok_d;
   logic               silent_q, silent_d;
   logic [11:0]        cnt_q, cnt_d;
   logic               trunc_q, trunc_d;
   logic [11:0]        len_q, len_d;
   logic               err_q, err_d;
   logic [SLOT_W-1:0]  head_q, head_d;
   logic [SLOT_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [15:0]        mem_din_q, mem_din_d;
   logic [1:0]         mem_we_q, mem_we_d;
   logic               mem_en_q, mem_en_d;

   logic               beat, commit, release_ok, frame_end, drop_inc, too_short;
   logic [OCC_W:0]     occ_busy;
   logic [SLOT_W-1:0]  wr_slot;
   logic [11:0]        frame_len;
   logic               push;
   rx_desc_t           push_desc, pop_desc;
   logic               unused_desc_bits;

   always_comb begin
      state_d    = state_q;
      ready_d    = 1'b1;
      sof_ok_d   = sof_ok_q;
      silent_d   = silent_q;
      cnt_d      = cnt_q;
      trunc_d    = trunc_q;
      len_d      = len_q;
      err_d      = err_q;
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      drop_d     = drop_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 2'b00;
      mem_en_d   = 1'b0;
      frame_end  = 1'b0;
      drop_inc   = 1'b0;
      push       = 1'b0;
      push_desc  = '0;

      beat       = s_axis_tvalid && ready_q;
      commit     = (state_q == COMMIT);
      release_ok = buf_release && (occ_q != '0);
      // The slot being committed this cycle already counts as occupied for a new frame.
      occ_busy   = {1'b0, occ_q} + {{OCC_W{1'b0}}, commit};
      wr_slot    = commit ? head_q + 1'b1 : head_q;

      if (commit) begin
         push           = 1'b1;
         push_desc.len  = len_q;
         push_desc.slot = DESC_SLOT_W'(head_q);
         push_desc.err  = err_q;
         head_d         = head_q + 1'b1;
      end
      if (release_ok) begin
         tail_d = tail_q + 1'b1;
      end
      case ({commit, release_ok})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      if (beat && s_axis_tlast) begin
         sof_ok_d = 1'b1;
      end

      case (state_q)
         IDLE, COMMIT: begin
            state_d = IDLE;
            if (beat) begin
               cnt_d   = 12'd1;
               trunc_d = 1'b0;
               if (!sof_ok_q || (occ_busy >= (OCC_W+1)'(BUF_COUNT))) begin
                  // Mid-frame bytes after reset are swallowed without being counted.
                  silent_d = !sof_ok_q;
                  if (s_axis_tlast) begin
                     drop_inc = sof_ok_q;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  mem_en_d   = 1'b1;
                  mem_we_d   = 2'b01;
                  mem_addr_d = {wr_slot, {SLOT_HW_W{1'b0}}};
                  mem_din_d  = {s_axis_tdata, s_axis_tdata};
                  frame_end  = s_axis_tlast;
                  state_d    = RECV;
               end
            end
         end
         RECV: begin
            if (beat) begin
               if (cnt_q < 12'(SLOT_BYTES)) begin
                  mem_en_d   = 1'b1;
                  mem_we_d   = cnt_q[0] ? 2'b10 : 2'b01;
                  mem_addr_d = {head_q, cnt_q[SLOT_HW_W:1]};
                  mem_din_d  = {s_axis_tdata, s_axis_tdata};
                  cnt_d      = cnt_q + 12'd1;
               end else begin
                  trunc_d = 1'b1;
               end
               frame_end = s_axis_tlast;
            end
         end
         DROP: begin
            if (beat && s_axis_tlast) begin
               drop_inc = !silent_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef ETH_RX_FCS_STRIP_EN
      too_short = (cnt_d <= 12'(FCS_BYTES));
      frame_len = cnt_d - 12'(FCS_BYTES);
`else
      too_short = 1'b0;
      frame_len = cnt_d;
`endif

      if (frame_end) begin
         if (s_axis_tuser || too_short) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
         end else begin
            state_d = COMMIT;
            len_d   = frame_len;
            err_d   = trunc_d;
         end
      end

      if (drop_inc && (drop_q != '1)) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         sof_ok_q   <= 1'b0;
         silent_q   <= 1'b0;
         cnt_q      <= '0;
         trunc_q    <= 1'b0;
         len_q      <= '0;
         err_q      <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         drop_q     <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= '0;
         mem_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         sof_ok_q   <= sof_ok_d;
         silent_q   <= silent_d;
         cnt_q      <= cnt_d;
         trunc_q    <= trunc_d;
         len_q      <= len_d;
         err_q      <= err_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         drop_q     <= drop_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         mem_en_q   <= mem_en_d;
      end
   end

   eth_rx_desc_fifo #(
      .DEPTH (BUF_COUNT)
   ) u_desc_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_desc (push_desc),
      .pop_valid (desc_valid),
      .pop_ready (desc_ready),
      .pop_desc  (pop_desc)
   );

   assign s_axis_tready    = ready_q;
   assign mem_addr         = mem_addr_q;
   assign mem_din          = mem_din_q;
   assign mem_we           = mem_we_q;
   assign mem_en           = mem_en_q;
   assign drop_count       = drop_q;
   assign desc_len         = pop_desc.len;
   assign desc_slot        = pop_desc.slot[SLOT_W-1:0];
   assign desc_err         = pop_desc.err;
   assign unused_desc_bits = ^pop_desc.slot;

endmodule

// File: tb/tb_eth_rx_buf_writer.sv
// Directed self-checking bench for eth_rx_buf_writer (honours ETH_RX_FCS_STRIP_EN).
module tb_eth_rx_buf_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
   logic [12:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_we;
   logic        mem_en;
   logic        desc_valid, desc_ready;
   logic [11:0] desc_len;
   logic [2:0]  desc_slot;
   logic        desc_err;
   logic        buf_release;
   logic [15:0] drop_count;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned last_cyc, first_cyc;

   logic [12:0] wa[$];
   logic [1:0]  ww[$];
   logic [15:0] wd[$];
   int unsigned wc[$];
   logic [11:0] dl[$];
   logic [2:0]  ds[$];
   logic        de[$];
   int unsigned dc[$];

   eth_rx_buf_writer #(
      .BUF_COUNT (8),
      .SLOT_HW_W (10),
      .ADDR_W    (13),
      .CNT_W     (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .mem_addr      (mem_addr),
      .mem_din       (mem_din),
      .mem_we        (mem_we),
      .mem_en        (mem_en),
      .desc_valid    (desc_valid),
      .desc_ready    (desc_ready),
      .desc_len      (desc_len),
      .desc_slot     (desc_slot),
      .desc_err      (desc_err),
      .buf_release   (buf_release),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_en) begin
         wa.push_back(mem_addr);
         ww.push_back(mem_we);
         wd.push_back(mem_din);
         wc.push_back(cyc);
      end
      if (desc_valid && desc_ready) begin
         dl.push_back(desc_len);
         ds.push_back(desc_slot);
         de.push_back(desc_err);
         dc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_len(input int unsigned n);
`ifdef ETH_RX_FCS_STRIP_EN
      return n - 4;
`else
      return n;
`endif
   endfunction

   task automatic clear_logs();
      wa.delete(); ww.delete(); wd.delete(); wc.delete();
      dl.delete(); ds.delete(); de.delete(); dc.delete();
   endtask

   task automatic idle(input int unsigned n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      s_axis_tdata = 8'h00; buf_release = 1'b0; desc_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = 8'hEE;
      tick();
      idle(3);
      clear_logs();
   endtask

   task automatic send(input int unsigned n, input logic err, input logic [7:0] seed,
                       input bit b2b, input bit rel);
      for (int unsigned i = 0; i < n; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = seed + 8'(i);
         s_axis_tlast  = (i == n - 1);
         s_axis_tuser  = (i == n - 1) ? err : 1'b0;
         if (i == 0) first_cyc = cyc;
         if (i == n - 1) last_cyc = cyc;
         tick();
      end
      if (!b2b) begin
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
      end
      if (rel) begin
         buf_release = 1'b1;
         tick();
         buf_release = 1'b0;
      end
   endtask

   task automatic check_writes(input string tag, input int unsigned base, input int unsigned slot,
                               input int unsigned nw, input logic [7:0] seed);
      int unsigned mism = 0;
      logic [7:0] b;
      for (int unsigned i = 0; i < nw; i++) begin
         b = seed + 8'(i);
         if (base + i >= wa.size()) mism++;
         else if (wa[base+i] !== 13'(slot * 1024 + i / 2) ||
                  ww[base+i] !== ((i % 2 == 1) ? 2'b10 : 2'b01) ||
                  wd[base+i] !== {b, b}) mism++;
      end
      chk(tag, mism, 0);
   endtask

   initial begin
      // power-on reset values
      rst = 1'b1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      s_axis_tdata = 8'h00; buf_release = 1'b0; desc_ready = 1'b0;
      repeat (3) tick();
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_desc_valid", desc_valid, 0);
      chk("rst_desc_len", desc_len, 0);
      chk("rst_desc_slot", desc_slot, 0);
      chk("rst_desc_err", desc_err, 0);
      chk("rst_drop", drop_count, 0);
      rst = 1'b0;
      tick();
      chk("tready_after_rst", s_axis_tready, 1);
      // a lone tlast beat before any alignment is swallowed silently
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = 8'hEE;
      tick();
      idle(3);
      chk("flush_no_write", wa.size(), 0);
      chk("flush_no_drop", drop_count, 0);
      chk("flush_no_desc", desc_valid, 0);

      // 60-byte good frame
      clear_logs();
      desc_ready = 1'b1;
      send(60, 1'b0, 8'h00, 0, 0);
      idle(5);
      chk("f60_nwrites", wa.size(), 60);
      check_writes("f60_writes", 0, 0, 60, 8'h00);
      chk("f60_last_addr", wa[59], 29);
      chk("f60_write_latency", wc[0] - first_cyc, 1);
      chk("f60_ndesc", dl.size(), 1);
      chk("f60_len", dl[0], exp_len(60));
      chk("f60_slot", ds[0], 0);
      chk("f60_err", de[0], 0);
      chk("f60_desc_latency", dc[0] - last_cyc, 2);
      chk("f60_en_idle", mem_en, 0);

      // 61-byte then back-to-back 64-byte frame, descriptors held in the FIFO
      reset_dut();
      desc_ready = 1'b0;
      send(61, 1'b0, 8'h10, 1, 0);
      send(64, 1'b0, 8'h40, 0, 0);
      idle(5);
      chk("b2b_nwrites", wa.size(), 125);
      check_writes("b2b_first", 0, 0, 61, 8'h10);
      check_writes("b2b_second", 61, 1, 64, 8'h40);
      chk("b2b_last_addr", wa[60], 30);
      chk("b2b_last_we", ww[60], 2'b01);
      chk("b2b_second_addr", wa[61], 1024);
      chk("b2b_no_gap", wc[61] - wc[60], 1);
      chk("b2b_d0_valid", desc_valid, 1);
      chk("b2b_d0_len", desc_len, exp_len(61));
      chk("b2b_d0_slot", desc_slot, 0);
      chk("b2b_d0_err", desc_err, 0);
      tick(); tick();
      chk("b2b_d0_stable", desc_len, exp_len(61));
      desc_ready = 1'b1; tick(); desc_ready = 1'b0;
      chk("b2b_d1_valid", desc_valid, 1);
      chk("b2b_d1_len", desc_len, exp_len(64));
      chk("b2b_d1_slot", desc_slot, 1);
      desc_ready = 1'b1; tick(); desc_ready = 1'b0;
      chk("b2b_empty", desc_valid, 0);

      // errored frame, then a good one; release with nothing occupied is ignored
      reset_dut();
      buf_release = 1'b1; tick(); buf_release = 1'b0;
      send(30, 1'b1, 8'h20, 0, 0);
      idle(5);
      chk("err_drop", drop_count, 1);
      chk("err_no_desc", dl.size(), 0);
      send(40, 1'b0, 8'h30, 0, 0);
      idle(5);
      chk("err_next_ndesc", dl.size(), 1);
      chk("err_next_slot", ds[0], 0);
      chk("err_next_len", dl[0], exp_len(40));
      check_writes("err_next_writes", 30, 0, 40, 8'h30);

      // fill all slots, overflow, release, release coincident with commit
      reset_dut();
      for (int unsigned f = 0; f < 8; f++) begin
         send(8, 1'b0, 8'(f * 16), 0, 0);
         idle(3);
      end
      begin
         int unsigned mism = 0;
         for (int unsigned i = 0; i < 8; i++) if (ds[i] !== 3'(i)) mism++;
         chk("fill_slots", mism, 0);
      end
      chk("fill_ndesc", dl.size(), 8);
      chk("fill_drop0", drop_count, 0);
      send(8, 1'b0, 8'hA0, 0, 0);
      idle(3);
      chk("full_drop", drop_count, 1);
      chk("full_no_desc", dl.size(), 8);
      chk("full_no_write", wa.size(), 64);
      buf_release = 1'b1; tick(); buf_release = 1'b0;
      idle(2);
      send(8, 1'b0, 8'hB0, 0, 1);
      idle(3);
      chk("rel_ndesc", dl.size(), 9);
      chk("rel_slot", ds[8], 0);
      send(8, 1'b0, 8'hC0, 0, 0);
      idle(3);
      chk("relc_ndesc", dl.size(), 10);
      chk("relc_slot", ds[9], 1);
      chk("relc_drop", drop_count, 1);
      send(8, 1'b0, 8'hD0, 0, 0);
      idle(3);
      chk("refull_drop", drop_count, 2);
      chk("refull_ndesc", dl.size(), 10);

      // oversize frame truncated at the slot boundary
      reset_dut();
      send(2100, 1'b0, 8'h5A, 0, 0);
      idle(5);
      chk("big_nwrites", wa.size(), 2048);
      check_writes("big_writes", 0, 0, 2048, 8'h5A);
      chk("big_last_addr", wa[2047], 1023);
      chk("big_last_we", ww[2047], 2'b10);
      chk("big_ndesc", dl.size(), 1);
      chk("big_len", dl[0], exp_len(2048));
      chk("big_err", de[0], 1);

      // reset in the middle of a frame
      reset_dut();
      for (int unsigned i = 0; i < 50; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'h70 + 8'(i);
         s_axis_tlast  = (i == 49);
         s_axis_tuser  = 1'b0;
         if (i == 20) begin
            rst = 1'b1;
            #1;
            chk("mid_rst_tready", s_axis_tready, 0);
            chk("mid_rst_mem_en", mem_en, 0);
            chk("mid_rst_mem_we", mem_we, 0);
            chk("mid_rst_mem_addr", mem_addr, 0);
            chk("mid_rst_mem_din", mem_din, 0);
            chk("mid_rst_desc_valid", desc_valid, 0);
            chk("mid_rst_drop", drop_count, 0);
            clear_logs();
         end
         if (i == 23) rst = 1'b0;
         tick();
      end
      idle(4);
      chk("mid_rest_no_write", wa.size(), 0);
      chk("mid_rest_no_drop", drop_count, 0);
      chk("mid_rest_no_desc", dl.size(), 0);
      send(30, 1'b0, 8'h80, 0, 0);
      idle(5);
      chk("mid_next_nwrites", wa.size(), 30);
      check_writes("mid_next_writes", 0, 0, 30, 8'h80);
      chk("mid_next_slot", ds[0], 0);
      chk("mid_next_len", dl[0], exp_len(30));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_rx_buf_writer.md
Name: eth_rx_buf_writer

Overview:
Receive-side writer feeding the narrow (16-bit, byte-lane-enabled) port of the Ethernet dual-port frame buffer. It accepts the MAC's byte stream and steers each frame into one of BUF_COUNT fixed 2 KiB slots. For every good frame it emits a length/slot descriptor to the CPU-side consumer. Slots are recycled by an explicit release pulse; the MAC is never back-pressured, and frames that cannot be stored are dropped and counted.

Parameters:
BUF_COUNT, 8, number of frame slots (power of 2)
SLOT_HW_W, 10, halfword address bits per slot (1024 halfwords = 2048 bytes)
ADDR_W, 13, memory halfword address width = log2(BUF_COUNT)+SLOT_HW_W
CNT_W, 16, drop counter width

Ports:
clk  in  1  single clock, also drives buffer port A
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  8  received byte
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  always 1 out of reset
s_axis_tlast  in  1  last byte of frame
s_axis_tuser  in  1  frame error, sampled with tlast
mem_addr  out  ADDR_W  {slot, halfword offset}
mem_din  out  16  {byte, byte}
mem_we  out  2  byte-lane write enable
mem_en  out  1  port enable
desc_valid  out  1  descriptor available
desc_ready  in  1  consumer accepts descriptor
desc_len  out  12  frame byte count (1..2048)
desc_slot  out  log2(BUF_COUNT)  slot holding the frame
desc_err  out  1  frame truncated
buf_release  in  1  one-cycle pulse; frees oldest occupied slot
drop_count  out  CNT_W  frames dropped, saturating

Behaviour:
- Reset values: s_axis_tready 0, then 1 from the first cycle after rst deasserts. mem_addr 0, mem_din 0, mem_we 0, mem_en 0. desc_valid 0; desc fields 0. drop_count 0. Head/tail slot pointers 0, occupancy 0. FSM in IDLE.
- Byte k of a frame, accepted in cycle N, appears on the memory port in cycle N+1 (registered):
  - mem_addr = {head, k[10:1]}.
  - mem_we = 2'b01 if k even, 2'b10 if k odd (little-endian).
  - mem_en = 1; otherwise mem_en and mem_we are 0.
- FSM states:
  - IDLE: first valid byte goes to RECV if occupancy < BUF_COUNT, else to DROP. A single-byte frame (tvalid and tlast together) is handled as RECV or DROP terminating immediately.
  - RECV: write bytes. At the tlast beat:
    - tuser=1: discard, slot not consumed, drop_count+1, go to IDLE.
    - else go to COMMIT.
  - RECV overflow: when k reaches 2048, further bytes are not written, and a truncated flag is set. The frame still commits with len 2048 and err 1.
  - DROP: swallow bytes until tlast, increment drop_count, return to IDLE.
  - COMMIT (1 cycle): push {len, head, err} into the descriptor FIFO, head+1 (wraps modulo BUF_COUNT), occupancy+1, return to IDLE. Bytes arriving in COMMIT start the next frame exactly as in IDLE. There is no lost cycle; the FIFO push and the first write overlap.
- Descriptor latency: tlast accepted in cycle N -> desc_valid no earlier than N+2 (FIFO empty case).
- Descriptor FIFO: depth BUF_COUNT; it cannot overflow because descriptors ≤ occupied slots. Standard valid/ready; fields stable while desc_valid && !desc_ready.
- buf_release:
  - With occupancy 0: ignored.
  - Otherwise tail+1 and occupancy−1.
  - Coincident with COMMIT: occupancy unchanged, both pointers advance.
- drop_count saturates at all-ones.
- rst asserted mid-frame: everything returns to reset values, and the partial frame is abandoned. After reset, bytes of the interrupted frame still arriving before the next tlast are dropped, because the FSM enters DROP when the first byte seen is not known to be a start of frame. This is tracked by a sof_ok flag, cleared by reset and set by any tlast. These dropped bytes are not counted.

Optional Feature:
- Macro: ETH_RX_FCS_STRIP_EN.
- Defined: desc_len = bytes received − 4 (FCS removed from the reported length; bytes are still written). Frames with ≤4 bytes are dropped and counted.
- Undefined: desc_len includes FCS; no minimum-length check.

Decomposition:
- Package eth_rx_buf_pkg holds:
  - the FSM state enum (IDLE, RECV, DROP, COMMIT);
  - the rx_desc_t struct {len[11:0], slot, err};
  - constants SLOT_BYTES = 2048 and FCS_BYTES = 4.
- One sub-module, eth_rx_desc_fifo: synchronous FIFO of rx_desc_t, depth BUF_COUNT, with push/pop/valid/ready and the same clk/rst.

Test Plan:
- 60-byte good frame -> 60 writes, mem_addr 0..29, lanes alternating 01/10; descriptor len 60, slot 0, err 0, desc_valid at tlast+2.
- 61-byte frame then back-to-back 64-byte frame (no idle cycle) -> last write of the first frame at addr 30 we=01; second frame begins at addr 1024; descriptors (61,0) and (64,1) in order.
- Frame with tuser=1 on tlast -> no descriptor, drop_count=1; next good frame lands in slot 0.
- 8 frames with no release, then a 9th -> 9th dropped, drop_count=1; one buf_release, then a 10th frame -> slot 0; buf_release coincident with COMMIT keeps occupancy.
- 2100-byte frame -> writes stop after offset 1023 we=10; descriptor len 2048, err 1.
- rst pulsed during byte 20 of a frame -> all outputs at reset values; remainder of that frame ignored, drop_count 0; next frame written to slot 0 offset 0.
